// File: rtl/core_pkg.sv
// Shared types for the core's memory-side bridge: FSM states, access sizes, grant ids.
package core_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } arb_state_t;

    typedef enum logic {
        GNT_IFU,
        GNT_LSU
    } gnt_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/mem_arb_bridge_lane_align.sv
// Combinational byte-lane shifter: store data/strobe up, load data down, misalign flag.
module lane_align
    import core_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    input  logic [31:0] rdata_in,
    output logic [31:0] wdata_out,
    output logic [3:0]  wstrb_out,
    output logic [31:0] rdata_out,
    output logic        misalign
);

    logic [4:0] bit_shift;

    always_comb begin
        bit_shift = {addr_lo, 3'b000};
        wdata_out = wdata << bit_shift;
        wstrb_out = wmask << addr_lo;
        rdata_out = rdata_in >> bit_shift;
        misalign  = 1'b0;
        case (size)
            SZ_BYTE: misalign = 1'b0;
            SZ_HALF: misalign = addr_lo[0];
            default: misalign = (addr_lo != 2'b00);  // word and the reserved encoding
        endcase
    end

endmodule

// File: rtl/mem_arb_bridge.sv
// Merges ifu and lsu channels onto one memory port; lsu has priority, one transaction in flight.
module mem_arb_bridge
    import core_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ifu_reqValid,
    input  logic [31:0] ifu_addr,
    output logic        ifu_respValid,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_reqValid,
    input  logic [31:0] lsu_addr,
    input  logic [1:0]  lsu_size,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_respValid,
    output logic [31:0] lsu_rdata,
    output logic        mem_reqValid,
    input  logic        mem_reqReady,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_respValid,
    input  logic [31:0] mem_rdata,
    output logic        err
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    arb_state_t    state_q, state_d;
    gnt_t          gnt_q, gnt_sel;
    logic [31:0]   addr_q, sel_addr;
    logic [1:0]    size_q, sel_size;
    logic          wen_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic [TW-1:0] timer_q;
    logic [31:0]   ifu_rdata_q, lsu_rdata_q;
    logic          err_q;
    logic          req_any, timeout_hit;
    logic [1:0]    la_addr, la_size;
    logic [31:0]   al_wdata, al_rdata;
    logic [3:0]    al_wstrb;
    logic          al_misalign;

    always_comb begin
        req_any     = lsu_reqValid | ifu_reqValid;
        gnt_sel     = lsu_reqValid ? GNT_LSU : GNT_IFU;
        sel_addr    = lsu_reqValid ? lsu_addr : ifu_addr;
        sel_size    = lsu_reqValid ? lsu_size : SZ_WORD;
        // The shifter sees the incoming request while arbitrating, the captured one afterwards.
        la_addr     = (state_q == IDLE) ? sel_addr[1:0] : addr_q[1:0];
        la_size     = (state_q == IDLE) ? sel_size : size_q;
        timeout_hit = (timer_q == TW'(TIMEOUT - 1));
    end

    lane_align u_lane_align (
        .addr_lo   (la_addr),
        .size      (la_size),
        .wdata     (lsu_wdata),
        .wmask     (lsu_wmask),
        .rdata_in  (mem_rdata),
        .wdata_out (al_wdata),
        .wstrb_out (al_wstrb),
        .rdata_out (al_rdata),
        .misalign  (al_misalign)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req_any) state_d = al_misalign ? RESP : REQ;
            REQ:  if (mem_reqReady) state_d = WAIT;
            WAIT: if (mem_respValid || timeout_hit) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gnt_q       <= GNT_IFU;
            addr_q      <= '0;
            size_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            timer_q     <= '0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_any) begin
                        gnt_q   <= gnt_sel;
                        addr_q  <= sel_addr;
                        size_q  <= sel_size;
                        wen_q   <= lsu_reqValid & lsu_wen;
                        wdata_q <= lsu_reqValid ? al_wdata : '0;
                        wstrb_q <= (lsu_reqValid && lsu_wen) ? al_wstrb : 4'b0000;
                        if (al_misalign) begin
                            err_q <= 1'b1;
                            if (lsu_reqValid) lsu_rdata_q <= ERR_RDATA;
                            else              ifu_rdata_q <= ERR_RDATA;
                        end
                    end
                end
                REQ: begin
                    if (mem_reqReady) timer_q <= '0;
                end
                WAIT: begin
                    if (mem_respValid) begin
                        if (gnt_q == GNT_LSU) lsu_rdata_q <= wen_q ? '0 : al_rdata;
                        else                  ifu_rdata_q <= mem_rdata;
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                        if (gnt_q == GNT_LSU) lsu_rdata_q <= ERR_RDATA;
                        else                  ifu_rdata_q <= ERR_RDATA;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_reqValid  = (state_q == REQ);
        mem_addr      = {addr_q[31:2], 2'b00};
        mem_wen       = wen_q;
        mem_wdata     = wdata_q;
        mem_wstrb     = wstrb_q;
        ifu_respValid = (state_q == RESP) && (gnt_q == GNT_IFU);
        lsu_respValid = (state_q == RESP) && (gnt_q == GNT_LSU);
        ifu_rdata     = ifu_rdata_q;
        lsu_rdata     = lsu_rdata_q;
        err           = err_q;
    end

endmodule
